ppu_vram_port: RTL and testbench

CPU-facing VRAM access port for the PPU: implements the PPUADDR ($2006) address latch, the PPUDATA ($2007) read buffer and the address auto-increment. It drives the PPU memory controller's request side (14-bit address, write enable, write data) and consumes its synchronous read data. It sits between the PPU register-interface decode and the PPU memory controller.

---
 rtl/ppu_vram_port.sv | 94 +++++++++
 tb/tb_ppu_vram_port.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_port.sv
// CPU-side VRAM access port: PPUADDR latch, PPUDATA read buffer and address auto-increment.
// Drives the request side of the PPU memory controller, which returns read data one cycle after the address.
module ppu_vram_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ri_req,
  input  logic        ri_r_nw,
  input  logic [2:0]  ri_sel,
  input  logic [7:0]  ri_din,
  output logic [7:0]  ri_dout,
  output logic        ri_busy,
  input  logic        inc32,
  output logic [13:0] vram_addr,
  output logic        vram_wr,
  output logic [7:0]  vram_dout,
  input  logic [7:0]  vram_din
);

  typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_t;

  state_t      state, state_nxt;
  logic [13:0] v, t;
  logic        w;
  logic [7:0]  rd_buf, wdata;
  logic        accept;
  logic [13:0] v_inc;

  assign accept = ri_req && (state == IDLE);
  // 14-bit add wraps naturally, giving modulo-2^14 address arithmetic.
  assign v_inc  = v + (inc32 ? 14'd32 : 14'd1);

  // NOTE: async reset on the state register makes vram_wr (decoded from state) drop the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && ri_sel == 3'd7) state_nxt = ri_r_nw ? RD_ADDR : WR;
      WR:      state_nxt = IDLE;
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all register state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v       <= '0;
      t       <= '0;
      w       <= 1'b0;
      rd_buf  <= '0;
      wdata   <= '0;
      ri_dout <= '0;
    end else begin
      if (accept) begin
        case (ri_sel)
          3'd2: if (ri_r_nw) w <= 1'b0;
          3'd5: if (!ri_r_nw) w <= ~w;
          3'd6: if (!ri_r_nw) begin
            if (!w) begin
              t[13:8] <= ri_din[5:0];
              w       <= 1'b1;
            end else begin
              t[7:0]  <= ri_din;
              v       <= {t[13:8], ri_din};
              w       <= 1'b0;
            end
          end
          3'd7: begin
            if (ri_r_nw) ri_dout <= rd_buf;
            else         wdata   <= ri_din;
          end
          default: ;
        endcase
      end
      if (state == WR) v <= v_inc;
      if (state == RD_DATA) begin
        rd_buf <= vram_din;
        v      <= v_inc;
      end
    end
  end

  assign ri_busy   = (state != IDLE);
  assign vram_addr = v;
  assign vram_wr   = (state == WR);
  assign vram_dout = vram_wr ? wdata : 8'h00;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Testbench for ppu_vram_port: directed vector table, hand-written busy/reset sequences,
// and random register traffic checked against an operation-level model with its own memory image.
module tb_ppu_vram_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ri_req = 1'b0;
  logic        ri_r_nw = 1'b0;
  logic [2:0]  ri_sel = 3'd0;
  logic [7:0]  ri_din = 8'h00;
  logic [7:0]  ri_dout;
  logic        ri_busy;
  logic        inc32 = 1'b0;
  logic [13:0] vram_addr;
  logic        vram_wr;
  logic [7:0]  vram_dout;
  logic [7:0]  vram_din = 8'h00;

  ppu_vram_port dut (
    .clk(clk), .rst_n(rst_n), .ri_req(ri_req), .ri_r_nw(ri_r_nw), .ri_sel(ri_sel),
    .ri_din(ri_din), .ri_dout(ri_dout), .ri_busy(ri_busy), .inc32(inc32),
    .vram_addr(vram_addr), .vram_wr(vram_wr), .vram_dout(vram_dout), .vram_din(vram_din)
  );

  always #10 clk = ~clk;

  // Synchronous RAM standing in for the memory controller.
  logic [7:0] ram [16384];
  always @(posedge clk) begin
    if (vram_wr) ram[vram_addr] <= vram_dout;
    vram_din <= ram[vram_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operation-level reference model.
  int  mv, mt_hi, mt_lo, mbuf, mdout;
  bit  mw;
  byte unsigned mm [16384];

  task automatic model_reset();
    mv = 0; mt_hi = 0; mt_lo = 0; mbuf = 0; mdout = 0; mw = 1'b0;
  endtask

  // One CPU register access, run to completion, with model update and checks.
  task automatic do_op(input logic [2:0] sel, input bit rnw, input logic [7:0] din, input bit i32);
    int step;
    int n;
    int exp_n;
    step = i32 ? 32 : 1;
    exp_n = 0;
    ri_sel = sel; ri_r_nw = rnw; ri_din = din; inc32 = i32; ri_req = 1'b1;
    @(posedge clk); #1;
    ri_req = 1'b0;
    if (sel == 3'd7 && !rnw) begin
      check("wr_strobe", vram_wr, 1);
      check("wr_addr", vram_addr, mv);
      check("wr_data", vram_dout, din);
      mm[mv] = din;
      mv = (mv + step) % 16384;
      exp_n = 1;
    end else if (sel == 3'd7 && rnw) begin
      check("rd_dout_early", ri_dout, mbuf);
      check("rd_no_wr", vram_wr, 0);
      mdout = mbuf;
      mbuf = mm[mv];
      mv = (mv + step) % 16384;
      exp_n = 2;
    end else if (sel == 3'd6 && !rnw) begin
      if (!mw) begin
        mt_hi = din % 64;
        mw = 1'b1;
      end else begin
        mt_lo = din;
        mv = mt_hi * 256 + mt_lo;
        mw = 1'b0;
      end
    end else if (sel == 3'd5 && !rnw) begin
      mw = !mw;
    end else if (sel == 3'd2 && rnw) begin
      mw = 1'b0;
    end
    n = 0;
    while (ri_busy && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_cycles", n, exp_n);
    check("wr_idle", vram_wr, 0);
    check("addr_after", vram_addr, mv);
    check("dout_after", ri_dout, mdout);
  endtask

  typedef struct {
    logic [2:0]  sel;
    bit          rnw;
    logic [7:0]  din;
    bit          i32;
    logic [13:0] exp_addr;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin ram[i] = 8'h00; mm[i] = 8'h00; end
    model_reset();

    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h21, 1'b0, 14'h0000, 8'h00});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h08, 1'b0, 14'h2108, 8'h00});
    vecs.push_back(vec_t'{3'd7, 1'b0, 8'hAB, 1'b0, 14'h2109, 8'h00});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h00, 1'b0, 14'h2109, 8'h00});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h10, 1'b0, 14'h0010, 8'h00});
    vecs.push_back(vec_t'{3'd7, 1'b0, 8'h5A, 1'b0, 14'h0011, 8'h00});
    vecs.push_back(vec_t'{3'd7, 1'b0, 8'hC3, 1'b0, 14'h0012, 8'h00});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h00, 1'b0, 14'h0012, 8'h00});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h10, 1'b0, 14'h0010, 8'h00});
    vecs.push_back(vec_t'{3'd7, 1'b1, 8'h00, 1'b0, 14'h0011, 8'h00});
    vecs.push_back(vec_t'{3'd7, 1'b1, 8'h00, 1'b0, 14'h0012, 8'h5A});
    vecs.push_back(vec_t'{3'd7, 1'b1, 8'h00, 1'b0, 14'h0013, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h3F, 1'b0, 14'h0013, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'hF0, 1'b0, 14'h3FF0, 8'hC3});
    vecs.push_back(vec_t'{3'd7, 1'b0, 8'h11, 1'b1, 14'h0010, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h3F, 1'b0, 14'h0010, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'hFF, 1'b0, 14'h3FFF, 8'hC3});
    vecs.push_back(vec_t'{3'd7, 1'b0, 8'h22, 1'b0, 14'h0000, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h3F, 1'b0, 14'h0000, 8'hC3});
    vecs.push_back(vec_t'{3'd2, 1'b1, 8'h00, 1'b0, 14'h0000, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h12, 1'b0, 14'h0000, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h34, 1'b0, 14'h1234, 8'hC3});
    vecs.push_back(vec_t'{3'd5, 1'b0, 8'h00, 1'b0, 14'h1234, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h05, 1'b0, 14'h1205, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b1, 8'h77, 1'b0, 14'h1205, 8'hC3});
    vecs.push_back(vec_t'{3'd5, 1'b1, 8'h77, 1'b0, 14'h1205, 8'hC3});
    vecs.push_back(vec_t'{3'd0, 1'b0, 8'h99, 1'b0, 14'h1205, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'hFF, 1'b0, 14'h1205, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h00, 1'b0, 14'h3F00, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'h3F, 1'b0, 14'h3F00, 8'hC3});
    vecs.push_back(vec_t'{3'd6, 1'b0, 8'hF0, 1'b0, 14'h3FF0, 8'hC3});
    vecs.push_back(vec_t'{3'd7, 1'b1, 8'h00, 1'b0, 14'h3FF1, 8'h00});
    vecs.push_back(vec_t'{3'd7, 1'b1, 8'h00, 1'b0, 14'h3FF2, 8'h11});

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", vram_addr, 0);
    check("rst_wr", vram_wr, 0);
    check("rst_wdata", vram_dout, 0);
    check("rst_dout", ri_dout, 0);
    check("rst_busy", ri_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].sel, vecs[i].rnw, vecs[i].din, vecs[i].i32);
      check($sformatf("vec%0d_addr", i), vram_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_dout", i), ri_dout, vecs[i].exp_dout);
    end

    // Requests during a $2007 read's busy cycles are ignored; w stays set.
    do_op(3'd6, 1'b0, 8'h15, 1'b0);
    ri_sel = 3'd7; ri_r_nw = 1'b1; inc32 = 1'b0; ri_req = 1'b1;
    @(posedge clk); #1;
    check("abort_busy1", ri_busy, 1);
    ri_sel = 3'd6; ri_r_nw = 1'b0; ri_din = 8'h3F;
    @(posedge clk); #1;
    check("abort_busy2", ri_busy, 1);
    ri_sel = 3'd7; ri_r_nw = 1'b0; ri_din = 8'hEE;
    @(posedge clk); #1;
    ri_req = 1'b0;
    mdout = mbuf; mbuf = mm[mv]; mv = (mv + 1) % 16384;
    check("abort_idle", ri_busy, 0);
    check("abort_no_wr", vram_wr, 0);
    check("abort_addr", vram_addr, mv);
    check("abort_dout", ri_dout, mdout);
    do_op(3'd6, 1'b0, 8'h67, 1'b0);
    check("abort_t_w_kept", vram_addr, 14'h1567);

    // Reset asserted mid-write, with w left set beforehand.
    do_op(3'd6, 1'b0, 8'h2A, 1'b0);
    ri_sel = 3'd7; ri_r_nw = 1'b0; ri_din = 8'h77; ri_req = 1'b1;
    @(posedge clk); #1;
    ri_req = 1'b0;
    check("rstwr_strobe", vram_wr, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rstwr_async_wr", vram_wr, 0);
    check("rstwr_async_addr", vram_addr, 0);
    check("rstwr_async_busy", ri_busy, 0);
    check("rstwr_async_dout", ri_dout, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(3'd6, 1'b0, 8'h01, 1'b0);
    do_op(3'd6, 1'b0, 8'h02, 1'b0);
    check("rst_w_cleared", vram_addr, 14'h0102);

    // Random register traffic against the model.
    for (int k = 0; k < 300; k++) begin
      int r;
      logic [2:0] s;
      bit rw;
      r = $urandom_range(0, 9);
      if (r <= 3)      s = 3'd7;
      else if (r <= 5) s = 3'd6;
      else if (r == 6) s = 3'd5;
      else if (r == 7) s = 3'd2;
      else             s = 3'($urandom_range(0, 7));
      rw = (s == 3'd6) ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
      do_op(s, rw, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
